// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit registers, two combinational read
// ports and one synchronous write port, with x0 hardwired to zero.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_regWrite,
   input  logic [ADDR_WIDTH-1:0] i_regSelect1,
   input  logic [ADDR_WIDTH-1:0] i_regSelect2,
   input  logic [ADDR_WIDTH-1:0] i_writeRegSelect,
   input  logic [DATA_WIDTH-1:0] i_dataIn,
   output logic [DATA_WIDTH-1:0] o_dataOut1,
   output logic [DATA_WIDTH-1:0] o_dataOut2
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  write_en;

   // x0 is never stored; any write aimed at it is dropped here.
   assign write_en = i_regWrite && (i_writeRegSelect != '0);

   // NOTE: this storage is cleared by reset on purpose, because software relies
   // on every architectural register reading zero after reset; a plain RAM array
   // without a reset would be cheaper but would not give that guarantee.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[i_writeRegSelect] <= i_dataIn;
      end
   end

   // No write bypass: a same-cycle write becomes visible only after the edge.
   assign o_dataOut1 = (i_regSelect1 == '0) ? '0 : regs[i_regSelect1];
   assign o_dataOut2 = (i_regSelect2 == '0) ? '0 : regs[i_regSelect2];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// write/read traffic compared against an array model of the register file.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        reg_write;
   logic [4:0]  sel1;
   logic [4:0]  sel2;
   logic [4:0]  wsel;
   logic [31:0] data_in;
   logic [31:0] data_out1;
   logic [31:0] data_out2;

   logic [31:0] model [32];
   int          vectors;
   int          miscompares;

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_regWrite       (reg_write),
      .i_regSelect1     (sel1),
      .i_regSelect2     (sel2),
      .i_writeRegSelect (wsel),
      .i_dataIn         (data_in),
      .o_dataOut1       (data_out1),
      .o_dataOut2       (data_out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one rising edge with the given controls; the model follows the
   // architectural rules: reset clears all, writes to x0 vanish.
   task automatic tick(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
      rst_n     = rst;
      reg_write = we;
      wsel      = wa;
      data_in   = wd;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && wa != 5'd0) begin
         model[wa] = wd;
      end
      @(negedge clk);
      rst_n     = 1'b1;
      reg_write = 1'b0;
   endtask

   task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
      sel1 = a1;
      sel2 = a2;
      #1;
      check({tag, "_p1"}, data_out1, (a1 == 5'd0) ? 32'h0 : model[a1]);
      check({tag, "_p2"}, data_out2, (a2 == 5'd0) ? 32'h0 : model[a2]);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      reg_write   = 1'b0;
      sel1        = 5'd0;
      sel2        = 5'd0;
      wsel        = 5'd0;
      data_in     = 32'h0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      // x0 must read zero even before any reset edge.
      #1;
      check("x0_pre_reset_p1", data_out1, 32'h0);
      check("x0_pre_reset_p2", data_out2, 32'h0);

      @(negedge clk);
      tick(1'b0, 1'b0, 5'd0, 32'h0);
      tick(1'b0, 1'b0, 5'd0, 32'h0);
      read_pair("reset_x0", 5'd0, 5'd0);
      read_pair("reset_x17", 5'd17, 5'd31);

      tick(1'b1, 1'b1, 5'd5, 32'd42);
      read_pair("wr_x5", 5'd5, 5'd0);
      check("x5_literal", data_out1, 32'd42);

      tick(1'b1, 1'b1, 5'd0, 32'd99);
      read_pair("wr_x0", 5'd0, 5'd5);
      check("x0_literal", data_out1, 32'h0);
      for (int i = 0; i < 32; i++) read_pair("after_x0_write", 5'(i), 5'(31 - i));

      tick(1'b1, 1'b1, 5'd10, 32'd100);
      tick(1'b1, 1'b1, 5'd15, 32'd200);
      read_pair("b2b_10_15", 5'd10, 5'd15);
      read_pair("b2b_15_15", 5'd15, 5'd15);
      check("x15_literal", data_out2, 32'd200);

      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 5'd10, 32'd7);
      read_pair("we_low_x10", 5'd10, 5'd5);
      check("x10_literal", data_out1, 32'd100);

      // Reset wins over a simultaneous write.
      tick(1'b0, 1'b1, 5'd10, 32'h1234_5678);
      for (int i = 0; i < 32; i++) read_pair("reset_vs_write", 5'(i), 5'(i));

      // Read during write: old value before the edge, new one right after.
      tick(1'b1, 1'b1, 5'd3, 32'h0000_0055);
      sel1      = 5'd3;
      sel2      = 5'd3;
      reg_write = 1'b1;
      wsel      = 5'd3;
      data_in   = 32'hDEAD_BEEF;
      #1;
      check("rdw_before_edge", data_out1, 32'h0000_0055);
      @(posedge clk);
      #1;
      check("rdw_after_edge_p1", data_out1, 32'hDEAD_BEEF);
      check("rdw_after_edge_p2", data_out2, 32'hDEAD_BEEF);
      model[3] = 32'hDEAD_BEEF;
      @(negedge clk);
      reg_write = 1'b0;

      // Random traffic: writes biased to hit x0 now and then, rare resets.
      for (int n = 0; n < 600; n++) begin
         logic        r_rst;
         logic        r_we;
         logic [4:0]  r_wa;
         logic [31:0] r_wd;
         r_rst = ($urandom_range(0, 99) != 0);
         r_we  = ($urandom_range(0, 3) != 0);
         r_wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         r_wd  = $urandom;
         tick(r_rst, r_we, r_wa, r_wd);
         read_pair("rand", 5'($urandom_range(0, 31)), r_wa);
      end
      for (int i = 0; i < 32; i++) read_pair("final_sweep", 5'(i), 5'(31 - i));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
